// File: rtl/screen_arbiter.sv
// screen_arbiter: shares the CPU screen-memory read port between two readers
// Requester 0 is the OLED bridge, requester 1 a secondary reader (frame dump / debug).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_read/idx/lock (in)          per-requester read level, byte index, frame lock
//   reqN_byte/ack (out)              per-requester returned data and one-cycle done pulse
//   scr_busy (in)                    CPU is drawing; blocks new grants only
//   scr_read/scr_read_idx (out)      downstream read request and index
//   scr_read_byte/scr_read_ack (in)  downstream data and completion pulse
//   owner (out)                      requester currently or last granted
//   timeout_err (out)                sticky, set when a read is aborted for lack of ack
module screen_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_read,
    input  logic [7:0] req0_idx,
    input  logic       req0_lock,
    output logic [7:0] req0_byte,
    output logic       req0_ack,
    input  logic       req1_read,
    input  logic [7:0] req1_idx,
    input  logic       req1_lock,
    output logic [7:0] req1_byte,
    output logic       req1_ack,
    input  logic       scr_busy,
    output logic       scr_read,
    output logic [7:0] scr_read_idx,
    input  logic [7:0] scr_read_byte,
    input  logic       scr_read_ack,
    output logic       owner,
    output logic       timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    // The counter holds the number of completed ISSUE cycles, so the abort
    // fires on the edge that would bring it to TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state, w_state;
    logic [7:0] r_cnt, w_cnt;
    logic       r_owner, w_owner;
    logic       r_read, w_read;
    logic [7:0] r_idx, w_idx;
    logic [7:0] r_byte0, w_byte0;
    logic [7:0] r_byte1, w_byte1;
    logic       r_ack0, w_ack0;
    logic       r_ack1, w_ack1;
    logic       r_terr, w_terr;

    logic       w_lock, w_cand0, w_cand1, w_grant, w_win, w_timeout;
    logic [7:0] w_rdata;

    // A lock only counts when held by the current owner; it excludes the other requester.
    assign w_lock    = r_owner ? req1_lock : req0_lock;
    assign w_cand0   = req0_read & (!w_lock | !r_owner);
    assign w_cand1   = req1_read & (!w_lock | r_owner);
    assign w_grant   = !scr_busy & (w_cand0 | w_cand1);
    assign w_win     = (w_cand0 & w_cand1) ? !r_owner : w_cand1;
    assign w_timeout = !scr_read_ack & (r_cnt == TO_LAST);
    assign w_rdata   = scr_read_ack ? scr_read_byte : 8'h00;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_owner = r_owner;
        w_read  = r_read;
        w_idx   = r_idx;
        w_byte0 = r_byte0;
        w_byte1 = r_byte1;
        w_ack0  = 1'b0;
        w_ack1  = 1'b0;
        w_terr  = r_terr;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state = ISSUE;
                    w_owner = w_win;
                    w_idx   = w_win ? req1_idx : req0_idx;
                    w_read  = 1'b1;
                    w_cnt   = 8'd0;
                end
            end
            ISSUE: begin
                w_cnt = (&r_cnt) ? r_cnt : r_cnt + 8'd1;
                // An ack on the last allowed cycle still wins over the abort.
                if (scr_read_ack || w_timeout) begin
                    w_state = RESP;
                    w_read  = 1'b0;
                    w_terr  = r_terr | w_timeout;
                    w_ack0  = !r_owner;
                    w_ack1  = r_owner;
                    if (r_owner)
                        w_byte1 = w_rdata;
                    else
                        w_byte0 = w_rdata;
                end
            end
            RESP:    w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_owner <= 1'b1;
            r_read  <= 1'b0;
            r_idx   <= 8'd0;
            r_byte0 <= 8'd0;
            r_byte1 <= 8'd0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_owner <= w_owner;
            r_read  <= w_read;
            r_idx   <= w_idx;
            r_byte0 <= w_byte0;
            r_byte1 <= w_byte1;
            r_ack0  <= w_ack0;
            r_ack1  <= w_ack1;
            r_terr  <= w_terr;
        end
    end

    assign scr_read     = r_read;
    assign scr_read_idx = r_idx;
    assign req0_byte    = r_byte0;
    assign req1_byte    = r_byte1;
    assign req0_ack     = r_ack0;
    assign req1_ack     = r_ack1;
    assign owner        = r_owner;
    assign timeout_err  = r_terr;
endmodule

// File: tb/tb_screen_arbiter.sv
// tb_screen_arbiter: self-checking bench for screen_arbiter
// Transaction-level reference: decides each grant from the arbitration rules,
// predicts returned bytes (idx ^ 8'h76, or 00 on abort) and ISSUE length.
module tb_screen_arbiter;
    localparam int TO = 4;

    logic       clk, rst_n, busy;
    logic       rd [2];
    logic       lk [2];
    logic [7:0] idx [2];
    logic [7:0] b0, b1, scr_read_idx, scr_read_byte;
    logic       a0, a1, scr_read, scr_read_ack, owner, timeout_err;
    logic       dn_ack, inj_ack;
    logic [7:0] dn_byte;
    int         lat, seen, cyc, passed, total, mode;

    int         m_owner, g_cyc, g_lat, last_who;
    logic       m_terr, prev_rd, prev_ack;
    logic [7:0] m_byte [2];
    logic [7:0] g_idx;
    int         n_ack [2];
    int         grants [$];

    typedef struct {
        logic       r0, r1, l0, l1;
        logic [7:0] i0, i1;
        int         lat;
        int         win;
        logic [7:0] byt;
        logic       terr;
    } vec_t;
    vec_t tbl [9];

    screen_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_read(rd[0]), .req0_idx(idx[0]), .req0_lock(lk[0]), .req0_byte(b0), .req0_ack(a0),
        .req1_read(rd[1]), .req1_idx(idx[1]), .req1_lock(lk[1]), .req1_byte(b1), .req1_ack(a1),
        .scr_busy(busy), .scr_read(scr_read), .scr_read_idx(scr_read_idx),
        .scr_read_byte(scr_read_byte), .scr_read_ack(scr_read_ack),
        .owner(owner), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign scr_read_ack  = dn_ack | inj_ack;
    assign scr_read_byte = dn_byte;

    // Downstream memory: acks `lat` cycles after seeing scr_read (lat 0 = never).
    initial begin
        dn_ack = 1'b0;
        dn_byte = 8'h00;
        seen = 0;
        forever begin
            @(posedge clk); #1;
            if (scr_read) seen++; else seen = 0;
            dn_ack = scr_read && lat != 0 && seen == lat;
            dn_byte = dn_ack ? (scr_read_idx ^ 8'h76) : 8'($urandom);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic on_ack(input int w);
        if (mode == 1) idx[w] = idx[w] + 8'd1;
        else if (mode == 2) begin
            rd[w]  = ($urandom_range(9) < 7);
            idx[w] = 8'($urandom);
            lk[w]  = rd[w] && ($urandom_range(3) == 0);
            lat    = $urandom_range(6, 1);
        end
    endtask

    task automatic step();
        int   w;
        logic to;
        logic c [2];
        @(posedge clk); #1;
        cyc++;
        if (scr_read && !prev_rd) begin
            for (int i = 0; i < 2; i++) c[i] = rd[i] && (!lk[m_owner] || i == m_owner);
            w = (c[0] && c[1]) ? 1 - m_owner : (c[1] ? 1 : 0);
            chk("grant_has_candidate", 32'(c[0] | c[1]), 1);
            chk("grant_not_busy", 32'(busy), 0);
            chk("grant_owner", 32'(owner), 32'(w));
            chk("grant_idx", 32'(scr_read_idx), 32'(idx[w]));
            m_owner = w;
            g_cyc = cyc;
            g_lat = lat;
            g_idx = idx[w];
            grants.push_back(w);
        end
        if (a0 || a1) begin
            to = (g_lat == 0 || g_lat > TO);
            chk("ack_onehot", 32'({a1, a0}), m_owner == 1 ? 2 : 1);
            chk("ack_single", 32'(prev_ack), 0);
            chk("issue_len", 32'(cyc - g_cyc), 32'(to ? TO : g_lat));
            m_terr = m_terr | to;
            m_byte[m_owner] = to ? 8'h00 : (g_idx ^ 8'h76);
            chk("ack_byte", 32'(m_owner == 1 ? b1 : b0), 32'(m_byte[m_owner]));
            chk("other_byte", 32'(m_owner == 1 ? b0 : b1), 32'(m_byte[1 - m_owner]));
            chk("timeout_err", 32'(timeout_err), 32'(m_terr));
            chk("read_dropped", 32'(scr_read), 0);
            n_ack[m_owner]++;
            last_who = m_owner;
            on_ack(m_owner);
        end
        prev_rd = scr_read;
        prev_ack = a0 | a1;
        if (mode == 2) begin
            for (int i = 0; i < 2; i++)
                if (!rd[i] && $urandom_range(3) == 0) begin
                    rd[i] = 1'b1;
                    idx[i] = 8'($urandom);
                    lk[i] = ($urandom_range(3) == 0);
                end
            busy = ($urandom_range(4) == 0);
        end
    endtask

    task automatic wait_ack(input string name, input int budget);
        int s, n;
        s = n_ack[0] + n_ack[1];
        n = 0;
        while (n_ack[0] + n_ack[1] == s && n < budget) begin
            step();
            n++;
        end
        chk({name, "_ack_seen"}, 32'(n_ack[0] + n_ack[1] != s), 1);
    endtask

    task automatic settle();
        rd[0] = 1'b0; rd[1] = 1'b0; lk[0] = 1'b0; lk[1] = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        int n, s0, s1, gs, nz;
        passed = 0; total = 0; cyc = 0; mode = 0; lat = 1; busy = 1'b0; inj_ack = 1'b0;
        rd[0] = 1'b0; rd[1] = 1'b0; lk[0] = 1'b0; lk[1] = 1'b0; idx[0] = 8'h00; idx[1] = 8'h00;
        m_owner = 1; m_terr = 1'b0; m_byte[0] = 8'h00; m_byte[1] = 8'h00;
        prev_rd = 1'b0; prev_ack = 1'b0; n_ack[0] = 0; n_ack[1] = 0; last_who = -1;
        g_cyc = 0; g_lat = 1; g_idx = 8'h00;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h2A, 8'h00, 2, 0, 8'h5C, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h20, 1, 1, 8'h56, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h21, 3, 0, 8'h67, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 4, 1, 8'h89, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 8'h00, 0, 0, 8'h00, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 8'h55, 1, 1, 8'h23, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 8'h77, 2, 1, 8'h01, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h68, 8'h79, 2, 0, 8'h1E, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h02, 1, 0, 8'h77, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scr_read", 32'(scr_read), 0);
        chk("rst_idx", 32'(scr_read_idx), 0);
        chk("rst_owner", 32'(owner), 1);
        chk("rst_acks", 32'({a1, a0}), 0);
        chk("rst_bytes", 32'({b1, b0}), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int t = 0; t < 9; t++) begin
            rd[0] = tbl[t].r0; rd[1] = tbl[t].r1; lk[0] = tbl[t].l0; lk[1] = tbl[t].l1;
            idx[0] = tbl[t].i0; idx[1] = tbl[t].i1; lat = tbl[t].lat;
            wait_ack("tbl", 30);
            chk("tbl_win", 32'(last_who), 32'(tbl[t].win));
            chk("tbl_byte", 32'(last_who == 1 ? b1 : b0), 32'(tbl[t].byt));
            chk("tbl_terr", 32'(timeout_err), 32'(tbl[t].terr));
            rd[0] = 1'b0; rd[1] = 1'b0; lk[0] = 1'b0; lk[1] = 1'b0;
        end

        settle();
        mode = 1; lat = 1; idx[0] = 8'h80; idx[1] = 8'h90; rd[0] = 1'b1; rd[1] = 1'b1;
        gs = grants.size(); s0 = n_ack[0] + n_ack[1]; n = 0;
        while (n_ack[0] + n_ack[1] - s0 < 8 && n < 100) begin
            step();
            n++;
        end
        rd[0] = 1'b0; rd[1] = 1'b0;
        chk("rr_cycles", 32'(n), 23);
        chk("rr_grants", 32'(grants.size() - gs), 8);
        if (grants.size() >= gs + 8)
            for (int k = 0; k < 8; k++) chk("rr_alt", 32'(grants[gs + k]), (k % 2 == 0) ? 1 : 0);

        settle();
        lk[0] = 1'b1; rd[0] = 1'b1; rd[1] = 1'b1; idx[0] = 8'hA0; idx[1] = 8'hB0;
        gs = grants.size(); s0 = n_ack[0]; s1 = n_ack[1]; n = 0;
        while (n_ack[0] - s0 < 10 && n < 200) begin
            step();
            n++;
        end
        chk("lock_req1_blocked", 32'(n_ack[1] - s1), 0);
        lk[0] = 1'b0;
        n = 0;
        while (grants.size() < gs + 11 && n < 10) begin
            step();
            n++;
        end
        rd[0] = 1'b0; rd[1] = 1'b0;
        chk("lock_count", 32'(grants.size() >= gs + 11), 1);
        if (grants.size() >= gs + 11) begin
            nz = 0;
            for (int k = 0; k < 10; k++) if (grants[gs + k] == 0) nz++;
            chk("lock_grants0", 32'(nz), 10);
            chk("lock_next1", 32'(grants[gs + 10]), 1);
        end
        wait_ack("lock_tail", 20);

        mode = 0;
        settle();
        busy = 1'b1; rd[0] = 1'b1; idx[0] = 8'hC3; lat = 3;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("busy_hold", 32'(scr_read), 0);
        end
        busy = 1'b0;
        step();
        chk("busy_release", 32'(scr_read), 1);
        busy = 1'b1;
        wait_ack("busy_issue", 20);
        rd[0] = 1'b0;
        busy = 1'b0;

        settle();
        rd[0] = 1'b1; idx[0] = 8'h99; lat = 0;
        wait_ack("timeout", 20);
        chk("to_byte", 32'(b0), 0);
        chk("to_err", 32'(timeout_err), 1);
        rd[0] = 1'b0;
        step();
        inj_ack = 1'b1;
        step();
        inj_ack = 1'b0;
        chk("late_ack_none", 32'({a1, a0}), 0);
        step();
        chk("late_ack_none2", 32'({a1, a0}), 0);
        chk("late_read", 32'(scr_read), 0);
        chk("late_byte", 32'(b0), 0);
        chk("late_terr", 32'(timeout_err), 1);

        settle();
        mode = 2; lat = 2;
        s0 = n_ack[0] + n_ack[1];
        repeat (3000) step();
        mode = 0; busy = 1'b0;
        settle();
        repeat (20) step();
        chk("rand_progress", 32'(n_ack[0] + n_ack[1] - s0 > 100), 1);

        settle();
        rd[0] = 1'b1; idx[0] = 8'h5A; lat = 0;
        n = 0;
        while (!scr_read && n < 5) begin
            step();
            n++;
        end
        step();
        chk("ar_in_issue", 32'({scr_read, owner}), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_read", 32'(scr_read), 0);
        chk("ar_owner", 32'(owner), 1);
        rd[0] = 1'b0;
        m_owner = 1; m_terr = 1'b0; m_byte[0] = 8'h00; m_byte[1] = 8'h00; prev_rd = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ar_no_ack", 32'({a1, a0}), 0);
        end
        chk("ar_terr", 32'(timeout_err), 0);
        chk("ar_byte", 32'(b0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd[0] = 1'b1; rd[1] = 1'b1; idx[0] = 8'h12; idx[1] = 8'h34; lat = 2;
        wait_ack("first_tie", 20);
        chk("first_tie_win", 32'(last_who), 0);
        settle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/screen_arbiter.md
# screen_arbiter

Shares the CPU's single screen-memory read port (`scr_read` / `scr_read_idx` / `scr_read_byte` / `scr_read_ack`) between two requesters. Requester 0 is the OLED screen bridge. Requester 1 is a secondary reader, such as a frame dumper or debug readout.

The block handles:
- round-robin arbitration, with an optional frame lock so one requester can read a coherent frame;
- holding off new reads while the CPU draws (`scr_busy`);
- a timeout watchdog so a missing ack cannot hang either requester.

It sits between the screen readers and `cpu` in `top`.

## Interface
Parameters:
- `TIMEOUT`, default 255: number of cycles in ISSUE without an ack before the read is aborted. Legal range is 1..255.

Ports:
- `clk`  in  1  system clock (16 MHz)
- `rst_n`  in  1  asynchronous, active-low reset
- `req0_read`  in  1  requester 0 read request, level
- `req0_idx`  in  8  requester 0 byte index
- `req0_lock`  in  1  requester 0 holds grant across reads
- `req0_byte`  out  8  read data returned to requester 0
- `req0_ack`  out  1  one-cycle completion pulse to requester 0
- `req1_read`, `req1_idx`, `req1_lock`, `req1_byte`, `req1_ack`: same as requester 0, for requester 1
- `scr_busy`  in  1  CPU is modifying screen memory
- `scr_read`  out  1  downstream read request, level
- `scr_read_idx`  out  8  downstream byte index
- `scr_read_byte`  in  8  downstream data, valid when `scr_read_ack` is high
- `scr_read_ack`  in  1  downstream completion pulse
- `owner`  out  1  requester currently or last granted
- `timeout_err`  out  1  sticky flag; set on any timeout

## Operation
States: IDLE, ISSUE, RESP.

IDLE:
- Candidates are requesters whose `read` is high.
- If the `lock` of `owner` is high, only `owner` may be granted.
- If both requesters are candidates with no lock, grant `!owner`.
- A grant requires `scr_busy` low.
- On a grant:
  - `owner` <= winner
  - latch the winner's idx into `scr_read_idx`
  - `scr_read` <= 1
  - go to ISSUE

ISSUE:
- `scr_read` is held high and `scr_read_idx` is held stable.
- On `scr_read_ack`:
  - latch `scr_read_byte` into the owner's `reqN_byte`
  - `scr_read` <= 0
  - go to RESP
- When the timeout counter reaches `TIMEOUT` with no ack:
  - owner's `reqN_byte` <= 8'h00
  - `timeout_err` <= 1
  - `scr_read` <= 0
  - go to RESP

RESP:
- The owner's `reqN_ack` is high for exactly this one cycle.
- Next state is IDLE.
- `read` inputs are not sampled in RESP. A requester deasserts `read` or presents its next idx by the cycle after its ack.

General rules:
- `scr_read_ack` arriving outside ISSUE (for example, late after a timeout) is ignored.
- `scr_busy` only gates new grants. A read already in ISSUE runs to completion.
- `reqN_byte` holds its value until that requester's next RESP. It is never changed by the other requester's traffic.
- The timeout counter is 8 bits. It is cleared on entry to ISSUE, increments each ISSUE cycle, and does not wrap.

## Timing
Reset (async assert, synchronous release):
- state IDLE
- `scr_read` 0, `scr_read_idx` 0
- `req0_ack`, `req1_ack` 0; `req0_byte`, `req1_byte` 0
- `owner` 1, so requester 0 wins the first tie
- `timeout_err` 0; counter 0

Reset mid-transaction drops `scr_read` immediately and no ack is issued.

Cycle-level sequence, where `req0_read` is sampled high at edge E0 (IDLE, not busy):
- `scr_read` is high after E0.
- The ack is sampled at edge Ek, so `req0_ack` is high from Ek to Ek+1.
- IDLE is re-entered at Ek+1.
- If downstream acks one cycle after seeing `scr_read`, round trip is 3 cycles from request sample to ack.

Other timing rules:
- Back-to-back throughput: one read per (downstream latency + 2) cycles. There is no dead cycle beyond the RESP cycle.
- Timeout: ISSUE lasts exactly `TIMEOUT` cycles, then RESP.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset and single read.** Release reset; `req0_read`=1, `req0_idx`=8'h2A. Downstream acks after 2 cycles with 8'h5C. Expect: `scr_read_idx`=8'h2A; `req0_ack` pulses exactly once with `req0_byte`=8'h5C; `owner`=0; `req1_ack` stays 0.
- **Round-robin.** Both requesters hold `read` high for 4 reads each, with no locks. Expect grants to alternate 0,1,0,1. Each `reqN_byte` matches the data returned for that requester's own idx.
- **Frame lock.** Requester 0 asserts `lock` for 10 reads while requester 1 requests continuously. Expect 10 consecutive grants to requester 0, then requester 1 granted on the next IDLE after lock drops.
- **Busy hold-off.** Assert `scr_busy` before a request. Expect `scr_read` to stay 0 until `scr_busy` falls, then rise one cycle later. Also assert `scr_busy` during ISSUE: the in-flight read still completes.
- **Timeout.** `TIMEOUT`=4 and downstream never acks. Expect: `scr_read` high for exactly 4 cycles; `req0_ack` with `req0_byte`=8'h00; `timeout_err`=1. A late `scr_read_ack` is ignored, and `timeout_err` stays set until reset.
- **Async reset in ISSUE.** Pull `rst_n` low while in ISSUE. Expect `scr_read` and `owner` to take their reset values immediately (without waiting for a clock edge), and no `reqN_ack` pulse.
